// File: rtl/jt51_so_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_so_tx_pkg
//  Description : Shared constants, float word type and slot helper for the
//                serial DAC output transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package jt51_so_tx_pkg;

    localparam int LIN_W        = 16;
    localparam int MAN_W        = 10;
    localparam int EXP_W        = 3;
    localparam int WORD_W       = MAN_W + EXP_W;
    localparam int SLOTS_PER_CH = 16;
    localparam int PAD_SLOTS    = 3;
    localparam int FRAME_W      = 32;
    localparam int SLOT_W       = 5;

    localparam logic [SLOT_W-1:0] SLOT_FIRST = 5'd0;
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = 5'd16;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = 5'd31;

    // Packed so that bit order LSB-first is mantissa[0..9] then exponent[0..2]
    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float_t;

    // Serial bit for sub-frame position k: padding first, then the word LSB-first
    function automatic logic word_bit(input float_t w, input logic [3:0] k);
        logic [WORD_W-1:0] bits;
        logic [3:0]        idx;
        bits = w;
        idx  = k - 4'(PAD_SLOTS);
        if (k < 4'(PAD_SLOTS)) begin
            return 1'b0;
        end
        return bits[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_lin2exp.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_lin2exp
//  Description : Signed 16-bit linear sample to 10-bit mantissa / 3-bit
//                exponent floating point (truncation toward -inf).
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_lin2exp
    import jt51_so_tx_pkg::*;
(
    input  logic [LIN_W-1:0] lin,
    output logic [MAN_W-1:0] man,
    output logic [EXP_W-1:0] exp
);

    // True when lin >>> sh is representable as a signed 10-bit value
    function automatic logic fits10(input logic [LIN_W-1:0] v, input int sh);
        logic signed [LIN_W-1:0] s;
        s = $signed(v) >>> sh;
        return (&s[LIN_W-1:MAN_W-1]) || ~(|s[LIN_W-1:MAN_W-1]);
    endfunction

    logic [EXP_W-1:0]        w_exp;
    logic signed [LIN_W-1:0] w_shifted;

    // Smallest exponent that fits; a shift of 6 always fits, so 7 is the clamp
    always_comb begin
        w_exp = 3'd7;
        for (int e = 6; e >= 1; e--) begin
            if (fits10(lin, e - 1)) begin
                w_exp = 3'(e);
            end
        end
        w_shifted = $signed(lin) >>> (w_exp - 3'd1);
        man       = w_shifted[MAN_W-1:0];
        exp       = w_exp;
    end

endmodule
`default_nettype wire

// File: rtl/jt51_so_tx.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_so_tx
//  Description : Serial DAC transmitter. Double-buffers left/right linear
//                samples, converts them to float at frame start and shifts
//                them out with SH1/SH2 sample-hold strobes (32-slot frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_so_tx
    import jt51_so_tx_pkg::*;
#(
    parameter bit REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              sample_stb,
    input  logic [LIN_W-1:0]  left,
    input  logic [LIN_W-1:0]  right,
    output logic              so,
    output logic              sh1,
    output logic              sh2,
    output logic              frame_start,
    output logic              ovf
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              so_q, so_d;
    logic              sh1_q, sh1_d;
    logic              sh2_q, sh2_d;
    logic              fs_q, fs_d;
    logic              ovf_q, ovf_d;
    logic              pend_vld_q, pend_vld_d;
    logic [LIN_W-1:0]  pend_l_q, pend_l_d;
    logic [LIN_W-1:0]  pend_r_q, pend_r_d;
    logic [LIN_W-1:0]  last_l_q, last_l_d;
    logic [LIN_W-1:0]  last_r_q, last_r_d;
    float_t            l_word_q, l_word_d;
    float_t            r_word_q, r_word_d;

    logic              w_load;
    logic              w_fresh;
    logic [LIN_W-1:0]  w_src_l;
    logic [LIN_W-1:0]  w_src_r;
    logic [MAN_W-1:0]  w_man_l, w_man_r;
    logic [EXP_W-1:0]  w_exp_l, w_exp_r;

    assign w_load = cen && (slot_q == SLOT_LAST);

    // Pick the linear pair for the next frame: a strobe in the load cycle wins
    always_comb begin
        w_fresh = sample_stb || pend_vld_q;
        if (sample_stb) begin
            w_src_l = left;
            w_src_r = right;
        end else if (pend_vld_q) begin
            w_src_l = pend_l_q;
            w_src_r = pend_r_q;
        end else if (REPEAT) begin
            w_src_l = last_l_q;
            w_src_r = last_r_q;
        end else begin
            w_src_l = '0;
            w_src_r = '0;
        end
    end

    jt51_lin2exp u_conv_l (
        .lin (w_src_l),
        .man (w_man_l),
        .exp (w_exp_l)
    );

    jt51_lin2exp u_conv_r (
        .lin (w_src_r),
        .man (w_man_r),
        .exp (w_exp_r)
    );

    // Slot counter, pin generation, frame load and pending-buffer capture
    always_comb begin
        slot_d     = slot_q;
        so_d       = so_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        fs_d       = 1'b0;
        ovf_d      = ovf_q;
        pend_vld_d = pend_vld_q;
        pend_l_d   = pend_l_q;
        pend_r_d   = pend_r_q;
        last_l_d   = last_l_q;
        last_r_d   = last_r_q;
        l_word_d   = l_word_q;
        r_word_d   = r_word_q;

        // Pins show the slot the counter held before this advance
        if (cen) begin
            slot_d = slot_q + 5'd1;
            so_d   = word_bit((slot_q >= SLOT_RIGHT) ? r_word_q : l_word_q,
                              slot_q[3:0]);
            sh1_d  = (slot_q < SLOT_RIGHT);
            sh2_d  = (slot_q >= SLOT_RIGHT);
        end

        if (w_load) begin
            l_word_d   = '{exp: w_exp_l, man: w_man_l};
            r_word_d   = '{exp: w_exp_r, man: w_man_r};
            pend_vld_d = 1'b0;
            fs_d       = 1'b1;
            if (w_fresh) begin
                last_l_d = w_src_l;
                last_r_d = w_src_r;
            end
        end

        // Capture ignores cen; a strobe that is consumed by the load stays clear
        if (sample_stb) begin
            pend_l_d = left;
            pend_r_d = right;
            if (!w_load) begin
                pend_vld_d = 1'b1;
                if (pend_vld_q) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= SLOT_FIRST;
            so_q       <= 1'b0;
            sh1_q      <= 1'b0;
            sh2_q      <= 1'b0;
            fs_q       <= 1'b0;
            ovf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_l_q   <= '0;
            pend_r_q   <= '0;
            last_l_q   <= '0;
            last_r_q   <= '0;
            l_word_q   <= '0;
            r_word_q   <= '0;
        end else begin
            slot_q     <= slot_d;
            so_q       <= so_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            fs_q       <= fs_d;
            ovf_q      <= ovf_d;
            pend_vld_q <= pend_vld_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            last_l_q   <= last_l_d;
            last_r_q   <= last_r_d;
            l_word_q   <= l_word_d;
            r_word_q   <= r_word_d;
        end
    end

    assign so          = so_q;
    assign sh1         = sh1_q;
    assign sh2         = sh2_q;
    assign frame_start = fs_q;
    assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: doc/jt51_so_tx.md
Name: jt51_so_tx

Overview:
- Serial output transmitter for the far end of the channel accumulator.
- Takes the exact left/right 16-bit linear samples latched once per sample period.
- Converts each to 10-bit mantissa + 3-bit exponent floating point and shifts both out as a DAC serial stream: SO data plus SH1/SH2 sample-hold strobes, in the external-DAC format.
- Double-buffers samples so the accumulator's sample strobe and the serial frame timing are decoupled.

Parameters:
- REPEAT, 1, 1: resend the last sample when no new sample arrived before frame start; 0: send zero (man=0, exp=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; one serial bit slot per cen=1 cycle
- sample_stb  in  1  one-cycle pulse: left/right valid (driven from c1_enters)
- left  in  16  signed linear left sample
- right  in  16  signed linear right sample
- so  out  1  serial data
- sh1  out  1  left sample-hold strobe
- sh2  out  1  right sample-hold strobe
- frame_start  out  1  one-cycle pulse, qualified by cen, at slot 0
- ovf  out  1  sticky overrun flag

Behaviour:
- Reset (async, rst_n=0):
  - slot counter = 0; so = 0, sh1 = 0, sh2 = 0, ovf = 0, frame_start = 0.
  - Pending buffer empty and zero; shift registers and last-sample registers zero.
- Slot counter:
  - 5-bit, advances only when cen=1; wraps 31 -> 0. One frame = 32 slots.
  - Slots 0-15 carry left, slots 16-31 carry right.
- Channel sub-frame, 16 slots (k = slot mod 16):
  - k=0..2: so = 0 (padding).
  - k=3..12: mantissa bits 0..9, LSB first.
  - k=13..15: exponent bits 0..2, LSB first.
- Strobes:
  - sh1 = 1 during slots 0-15, else 0.
  - sh2 = 1 during slots 16-31, else 0.
  - The DAC latches on the falling edge of each strobe.
- Output timing:
  - so/sh1/sh2 are registered and update on the same clk edge the counter advances.
  - Latency from counter value to pin is 1 clk.
- Linear-to-float conversion (per sample, combinational before the load):
  - exp = smallest e in 1..7 such that lin >>> (e-1) fits in signed 10 bits.
  - man = (lin >>> (exp-1))[9:0], truncation toward -inf.
  - Out-of-range values clamp at exp = 7.
- Pending buffer:
  - sample_stb=1 captures left/right into pending and sets pending_valid.
  - Capture is independent of cen.
- Frame load:
  - When the counter wraps to slot 0 (cen=1) and pending_valid=1: converted pending values load into the left/right shift words, pending_valid clears, and both values are stored as the last sample.
  - If pending_valid=0: REPEAT=1 loads the last sample; REPEAT=0 loads zero.
- Simultaneous sample_stb and frame load in the same clk:
  - The incoming left/right bypass to the shift words (newest sample wins).
  - pending_valid ends 0.
- Overrun:
  - sample_stb while pending_valid=1 and no load in that cycle sets ovf.
  - The old pending value is overwritten.
  - ovf clears only on reset.
- frame_start: 1 for the clk cycle in which the slot-0 load occurs.
- cen=0 indefinitely: all outputs hold; the pending buffer still accepts strobes.
- Reset mid-frame: outputs go to reset values immediately; the next frame starts at slot 0 with zero data.

Decomposition:
- Shared package: SLOTS_PER_CH=16, PAD_SLOTS=3, MAN_W=10, EXP_W=3, FRAME_W=32, slot index constants.
- Sub-module: reuse the existing jt51_lin2exp for the float conversion, instantiated twice (left, right) on the load path.
- Counter, buffers and shifter stay in this module.

Test Plan:
- Format, left=16'h0100, right=16'hFFFF, continuous cen:
  - Left sub-frame must carry man=0x100, exp=1: bits LSB-first 000 0000000010 100.
  - Right sub-frame must carry man=0x3FF, exp=1.
  - sh1 high for exactly slots 0-15, sh2 for slots 16-31.
- Exponent boundaries:
  - left=511 -> exp=1, man=511.
  - left=512 -> exp=2, man=256.
  - left=16'h4000 -> exp=7, man=256.
  - left=16'h7FFF -> exp=7, man=511.
  - left=16'h8000 -> exp=7, man=0x200.
- REPEAT=1 starvation: one strobe with left=1000, then none for 3 frames:
  - All three frames send exp=2, man=500.
  - With REPEAT=0, frames 2-3 send man=0, exp=1.
- Overrun: two strobes (values A, then B) inside one frame:
  - ovf=1.
  - The next frame transmits B.
- Collision: sample_stb in the same clk as the slot-0 load with left=-2048:
  - That frame carries exp=3, man=0x200.
  - pending_valid=0, ovf stays 0.
- Async reset asserted at slot 20 with cen toggling 1-in-4:
  - so/sh1/sh2 drop to 0 without waiting for clk.
  - After release, the first frame_start occurs 32 cen pulses later, carrying zero data.
